// File: rtl/mode_arbiter_pkg.sv
// mode_arbiter_pkg: shared types and constants for the mode arbiter slice.
//   state_t        - arbiter FSM states
//   MODE_*         - one-hot focus encodings driven on mode_sel
//   BTN_IDLE       - released level of an active-low 8-button bus
//   mode_onehot()  - state to mode_sel mapping (S_ALARM shows timer focus)
package mode_arbiter_pkg;

  typedef enum logic [1:0] {
    S_CLOCK,
    S_STOPWATCH,
    S_TIMER,
    S_ALARM
  } state_t;

  localparam logic [2:0] MODE_CLOCK     = 3'b001;
  localparam logic [2:0] MODE_STOPWATCH = 3'b010;
  localparam logic [2:0] MODE_TIMER     = 3'b100;

  localparam logic [7:0] BTN_IDLE = 8'hFF;

  function automatic logic [2:0] mode_onehot(input state_t s);
    logic [2:0] m;
    unique case (s)
      S_CLOCK:     m = MODE_CLOCK;
      S_STOPWATCH: m = MODE_STOPWATCH;
      S_TIMER:     m = MODE_TIMER;
      S_ALARM:     m = MODE_TIMER;
      default:     m = MODE_CLOCK;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus level debouncer for one
// active-low asynchronous button.
//   clk, rst  - system clock, asynchronous active-high reset
//   btn_raw   - asynchronous button input (idle high)
//   level     - debounced level (resets to 1)
//   rise      - one-cycle pulse when the debounced level goes 0->1
// The debounced level changes only after DEBOUNCE_CYCLES consecutive
// synchronized samples disagree with it; any agreeing sample restarts.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt   <= '0;
      level <= 1'b1;
      rise  <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        rise  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mode_arbiter.sv
// mode_arbiter: selects which of clock / stopwatch / timer units has
// focus, routes the function buttons to it and muxes its value to the
// display.
//   clk, rst                       - 12 MHz clock, async active-high reset
//   btn_mode                       - async active-low mode-cycle button
//   btn[7:0]                       - active-low function buttons
//   clk_value/sw_value/tmr_value   - unit values, VALUE_W bits each
//   tmr_alarm                      - timer end alarm is sounding
//   btn_clk/btn_sw/btn_tmr         - routed buttons (registered)
//   disp_value                     - displayed value (registered)
//   mode_sel                       - one-hot focus (registered)
// Build option: define MODE_ARBITER_ALARM_PREEMPT_EN to let tmr_alarm
// pre-empt clock/stopwatch focus; undefined leaves S_ALARM unreachable.
module mode_arbiter
  import mode_arbiter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned VALUE_W         = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_mode,
  input  logic [7:0]         btn,
  input  logic [VALUE_W-1:0] clk_value,
  input  logic [VALUE_W-1:0] sw_value,
  input  logic [VALUE_W-1:0] tmr_value,
  input  logic               tmr_alarm,
  output logic [7:0]         btn_clk,
  output logic [7:0]         btn_sw,
  output logic [7:0]         btn_tmr,
  output logic [VALUE_W-1:0] disp_value,
  output logic [2:0]         mode_sel
);

  logic   adv;
  logic   unused_mode_level;

  state_t state, state_nxt;
  state_t saved, saved_nxt;
  logic   swallow, swallow_nxt;  // alarm-exit press still held
  logic   guard, guard_nxt;      // focus moved while a press may be held
  logic   blocked;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_mode_db (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_mode),
    .level  (unused_mode_level),
    .rise   (adv)
  );

  always_comb begin
    state_nxt   = state;
    saved_nxt   = saved;
    swallow_nxt = swallow;
    guard_nxt   = guard;
    unique case (state)
      S_CLOCK: begin
`ifdef MODE_ARBITER_ALARM_PREEMPT_EN
        if (tmr_alarm) begin
          state_nxt = S_ALARM;
          saved_nxt = S_CLOCK;
        end else
`endif
        if (adv) state_nxt = S_STOPWATCH;
      end
      S_STOPWATCH: begin
`ifdef MODE_ARBITER_ALARM_PREEMPT_EN
        if (tmr_alarm) begin
          state_nxt = S_ALARM;
          saved_nxt = S_STOPWATCH;
        end else
`endif
        if (adv) state_nxt = S_TIMER;
      end
      S_TIMER: begin
        if (adv) state_nxt = S_CLOCK;
      end
      S_ALARM: begin
        if (btn != BTN_IDLE) begin
          state_nxt   = saved;
          swallow_nxt = 1'b1;
        end else if (!tmr_alarm) begin
          state_nxt = saved;
        end
      end
      default: state_nxt = S_CLOCK;
    endcase
    // Arm the guard on a focus move, then release both holds as soon as
    // the bus reads idle so a fresh press passes through undelayed.
    if (state_nxt != state) guard_nxt = 1'b1;
    if (btn == BTN_IDLE) begin
      guard_nxt   = 1'b0;
      swallow_nxt = 1'b0;
    end
    blocked = guard_nxt | swallow_nxt;
  end

  // Reset arms the guard so a button held through reset is not delivered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_CLOCK;
      saved      <= S_CLOCK;
      swallow    <= 1'b0;
      guard      <= 1'b1;
      btn_clk    <= BTN_IDLE;
      btn_sw     <= BTN_IDLE;
      btn_tmr    <= BTN_IDLE;
      disp_value <= '0;
      mode_sel   <= MODE_CLOCK;
    end else begin
      state    <= state_nxt;
      saved    <= saved_nxt;
      swallow  <= swallow_nxt;
      guard    <= guard_nxt;
      mode_sel <= mode_onehot(state_nxt);
      btn_clk  <= BTN_IDLE;
      btn_sw   <= BTN_IDLE;
      btn_tmr  <= BTN_IDLE;
      if (!blocked) begin
        unique case (state_nxt)
          S_CLOCK:     btn_clk <= btn;
          S_STOPWATCH: btn_sw  <= btn;
          S_TIMER:     btn_tmr <= btn;
          default:     ;
        endcase
      end
      unique case (state_nxt)
        S_CLOCK:     disp_value <= clk_value;
        S_STOPWATCH: disp_value <= sw_value;
        default:     disp_value <= tmr_value;
      endcase
    end
  end

endmodule

// File: tb/tb_mode_arbiter.sv
module tb_mode_arbiter;

  localparam int unsigned VW = 14;
`ifdef MODE_ARBITER_ALARM_PREEMPT_EN
  localparam bit ALARM_EN = 1'b1;
`else
  localparam bit ALARM_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          btn_mode;
  logic [7:0]    btn;
  logic [VW-1:0] clk_value;
  logic [VW-1:0] sw_value;
  logic [VW-1:0] tmr_value;
  logic          tmr_alarm;
  logic [7:0]    btn_clk;
  logic [7:0]    btn_sw;
  logic [7:0]    btn_tmr;
  logic [VW-1:0] disp_value;
  logic [2:0]    mode_sel;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  mode_arbiter #(
    .DEBOUNCE_CYCLES(4),
    .VALUE_W        (VW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_mode  (btn_mode),
    .btn       (btn),
    .clk_value (clk_value),
    .sw_value  (sw_value),
    .tmr_value (tmr_value),
    .tmr_alarm (tmr_alarm),
    .btn_clk   (btn_clk),
    .btn_sw    (btn_sw),
    .btn_tmr   (btn_tmr),
    .disp_value(disp_value),
    .mode_sel  (mode_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Step one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b0;
    tick(10);
    btn_mode = 1'b1;
    tick(10);
  endtask

  initial begin
    rst       = 1'b1;
    btn_mode  = 1'b1;
    btn       = 8'hFF;
    clk_value = 14'h0123;
    sw_value  = 14'h0456;
    tmr_value = 14'h0789;
    tmr_alarm = 1'b0;
    tick(3);
    check("rst_mode_sel", 32'(mode_sel), 32'h1);
    check("rst_disp", 32'(disp_value), 32'h0);
    check("rst_btn_clk", 32'(btn_clk), 32'hFF);

    rst = 1'b0;
    tick(2);
    check("pwr_mode_sel", 32'(mode_sel), 32'h1);
    check("pwr_disp", 32'(disp_value), 32'h0123);
    check("pwr_btn_sw", 32'(btn_sw), 32'hFF);
    check("pwr_btn_tmr", 32'(btn_tmr), 32'hFF);

    // 2-cycle glitch must not advance
    btn_mode = 1'b0;
    tick(2);
    btn_mode = 1'b1;
    tick(12);
    check("glitch_mode_sel", 32'(mode_sel), 32'h1);

    press_mode();
    check("p1_mode_sel", 32'(mode_sel), 32'h2);
    check("p1_disp", 32'(disp_value), 32'h0456);
    press_mode();
    check("p2_mode_sel", 32'(mode_sel), 32'h4);
    check("p2_disp", 32'(disp_value), 32'h0789);

    btn = 8'hFE;
    tick(1);
    check("tmr_btn_tmr", 32'(btn_tmr), 32'hFE);
    check("tmr_btn_clk", 32'(btn_clk), 32'hFF);
    check("tmr_btn_sw", 32'(btn_sw), 32'hFF);
    btn = 8'hFF;
    tick(1);
    check("tmr_btn_rel", 32'(btn_tmr), 32'hFF);

    press_mode();
    check("p3_mode_sel", 32'(mode_sel), 32'h1);
    press_mode();
    check("p4_mode_sel", 32'(mode_sel), 32'h2);

    // alarm while in stopwatch
    tmr_alarm = 1'b1;
    tick(2);
    check("alm_mode_sel", 32'(mode_sel), ALARM_EN ? 32'h4 : 32'h2);
    check("alm_disp", 32'(disp_value), ALARM_EN ? 32'h0789 : 32'h0456);
    btn       = 8'hFD;
    tmr_alarm = 1'b0;
    tick(1);
    check("almx_mode_sel", 32'(mode_sel), 32'h2);
    check("almx_btn_sw0", 32'(btn_sw), ALARM_EN ? 32'hFF : 32'hFD);
    tick(2);
    check("almx_btn_sw1", 32'(btn_sw), ALARM_EN ? 32'hFF : 32'hFD);
    btn = 8'hFF;
    tick(1);
    btn = 8'hFB;
    tick(1);
    check("almx_btn_sw2", 32'(btn_sw), 32'hFB);
    btn = 8'hFF;
    tick(1);

    // back to clock, then alarm coinciding with an advance event
    press_mode();
    press_mode();
    check("p6_mode_sel", 32'(mode_sel), 32'h1);
    btn_mode = 1'b0;
    tick(10);
    btn_mode = 1'b1;
    tick(6);
    tmr_alarm = 1'b1;
    tick(3);
    check("coin_mode_sel", 32'(mode_sel), ALARM_EN ? 32'h4 : 32'h2);
    tmr_alarm = 1'b0;
    tick(2);
    check("coin_ret_mode_sel", 32'(mode_sel), ALARM_EN ? 32'h1 : 32'h2);

    // reset while alarm is active and a button is held
    tmr_alarm = 1'b1;
    tick(2);
    btn       = 8'hFE;
    rst       = 1'b1;
    tmr_alarm = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("rsta_mode_sel", 32'(mode_sel), 32'h1);
    check("rsta_btn_clk0", 32'(btn_clk), 32'hFF);
    tick(2);
    check("rsta_btn_clk1", 32'(btn_clk), 32'hFF);
    btn = 8'hFF;
    tick(1);
    btn = 8'hFE;
    tick(1);
    check("rsta_btn_clk2", 32'(btn_clk), 32'hFE);
    check("rsta_disp", 32'(disp_value), 32'h0123);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mode_arbiter.md
MODE_ARBITER -- requirements
Module: mode_arbiter

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 120000, meaning the number of stable clk cycles required to accept a btn_mode level change (10 ms at 12 MHz).
REQ-002 The block SHALL have parameter VALUE_W, default 14, meaning the width of every time value bus.
REQ-003 The block SHALL have port clk  in  1  12 MHz system clock, all logic on posedge.
REQ-004 The block SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port btn_mode  in  1  mode-cycle button, active-low, asynchronous.
REQ-006 The block SHALL have port btn  in  8  function buttons, active-low, idle 8'hFF.
REQ-007 The block SHALL have port clk_value, sw_value, tmr_value  in  VALUE_W each  current values of the clock, stopwatch and timer units.
REQ-008 The block SHALL have port tmr_alarm  in  1  high while the timer unit is sounding its end alarm.
REQ-009 The block SHALL have port btn_clk, btn_sw, btn_tmr  out  8 each  routed buttons, active-low.
REQ-010 The block SHALL have port disp_value  out  VALUE_W  value driven to the display driver.
REQ-011 The block SHALL have port mode_sel  out  3  one-hot focus indicator: bit0 clock, bit1 stopwatch, bit2 timer.

Function
REQ-012 btn_mode SHALL pass through a 2-flop synchronizer, then a debouncer that updates its stable level only after DEBOUNCE_CYCLES consecutive equal synchronized samples; any differing sample restarts the count.
REQ-013 A mode advance event SHALL be the debounced level going 0->1 (release), one pulse per press.
REQ-014 The FSM SHALL have states S_CLOCK, S_STOPWATCH, S_TIMER, S_ALARM.
REQ-015 On advance event: S_CLOCK->S_STOPWATCH->S_TIMER->S_CLOCK; in S_ALARM advance events are ignored.
REQ-016 From S_CLOCK or S_STOPWATCH, tmr_alarm high SHALL move to S_ALARM next cycle, saving the departed state; tmr_alarm has priority over a same-cycle advance event.
REQ-017 In S_ALARM, any btn bit low SHALL return to the saved state next cycle; tmr_alarm falling also returns to the saved state.
REQ-018 The button press that exits S_ALARM SHALL be swallowed: all three btn_* outputs held 8'hFF until btn returns to 8'hFF.
REQ-019 In S_TIMER tmr_alarm SHALL cause no state change.
REQ-020 btn_* outputs SHALL be registered, 1-cycle latency: the focused unit (timer for S_ALARM-free states per mode_sel) receives btn, others 8'hFF; in S_ALARM all are 8'hFF.
REQ-021 On any focus change, the newly focused unit SHALL receive 8'hFF until btn reads 8'hFF (no partial press delivered).
REQ-022 disp_value SHALL be registered, 1-cycle latency: clk_value, sw_value or tmr_value per state; S_ALARM shows tmr_value.
REQ-023 mode_sel SHALL be one-hot for the focused state; in S_ALARM mode_sel=3'b100.

Reset
REQ-024 While rst is high: state S_CLOCK, saved state S_CLOCK, debounced level 1, debounce counter 0, swallow flag clear, btn_* 8'hFF, disp_value 0, mode_sel 3'b001.
REQ-025 Reset asserted mid-debounce or in S_ALARM SHALL discard all pending events; first cycle after release behaves as fresh power-up.

Configuration
REQ-026 Macro MODE_ARBITER_ALARM_PREEMPT_EN: defined -> REQ-016..018 active; undefined -> S_ALARM unreachable, tmr_alarm ignored, no swallow on alarm.

Structure
REQ-027 Shared package SHALL hold the state enum, the one-hot mode encodings and BTN_IDLE = 8'hFF.
REQ-028 The synchronizer plus debouncer SHALL be sub-module btn_debounce (parameter DEBOUNCE_CYCLES), reusable for other buttons.

Verification (DEBOUNCE_CYCLES=4, macro defined)
REQ-029 Reset release, btn_mode held 1 -> mode_sel 3'b001, disp_value=clk_value, btn_sw=btn_tmr=8'hFF.
REQ-030 btn_mode low 10 cycles then high 10 cycles -> exactly one advance, mode_sel 3'b010; a 2-cycle glitch -> no advance.
REQ-031 Three full presses -> mode_sel 001->010->100->001; btn=8'hFE in S_TIMER -> btn_tmr=8'hFE one cycle later, others 8'hFF.
REQ-032 In S_STOPWATCH, tmr_alarm=1 -> S_ALARM, disp_value=tmr_value, mode_sel 3'b100; btn=8'hFD -> back to S_STOPWATCH, btn_sw stays 8'hFF until btn=8'hFF.
REQ-033 tmr_alarm rises in the same cycle as an advance event from S_CLOCK -> S_ALARM, saved state S_CLOCK.
REQ-034 rst pulsed while in S_ALARM with btn held 8'hFE -> S_CLOCK, btn_clk 8'hFF until btn released.
